// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, command layout and default widths for the bus arbiter
package bus_pkg;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 32;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_ERR} arb_state_t;
  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] write_data;
  } bus_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting the search at ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any_gnt
);
  logic [IW-1:0] idx;
  // first requester at or after ptr, wrapping modulo N
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    any_gnt = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!any_gnt && req[idx]) begin
        any_gnt = 1'b1;
        gnt_id = idx;
      end
    end
    gnt[gnt_id] = any_gnt;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin N-master to 1-slave arbiter with timeout and illegal-command errors
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_write_data,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]             m_read_data,
  output logic                          s_valid,
  output logic                          s_read,
  output logic                          s_write,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_write_data,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_read_data,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                          busy
);
  localparam int GW = $clog2(NUM_MASTERS);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  arb_state_t state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d, grant_q, grant_d, rr_id, nxt_ptr;
  logic [NUM_MASTERS-1:0] rr_gnt;
  logic rr_any, legal, clr_cnt, timeout;
  logic s_valid_q, s_valid_d, s_read_q, s_read_d, s_write_q, s_write_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wd_q, s_wd_d;

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req(m_valid),
    .ptr(ptr_q),
    .gnt(rr_gnt),
    .gnt_id(rr_id),
    .any_gnt(rr_any)
  );

  assign legal = |(rr_gnt & (m_read ^ m_write));
  assign nxt_ptr = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;

  if (TIMEOUT_CYCLES > 0) begin : g_to
    logic [CW-1:0] cnt_q, cnt_d;
    // count BUSY cycles since the grant; cleared whenever a new grant is made
    always_comb cnt_d = clr_cnt ? '0 : (state_q == ARB_BUSY) ? cnt_q + 1'b1 : cnt_q;
    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
    assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  end else begin : g_no_to
    assign timeout = 1'b0;
    wire unused_clr = clr_cnt;
  end

  // next-state, payload capture and response routing
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    s_valid_d = s_valid_q;
    s_read_d = s_read_q;
    s_write_d = s_write_q;
    s_addr_d = s_addr_q;
    s_wd_d = s_wd_q;
    clr_cnt = 1'b0;
    m_ready = '0;
    m_err = '0;
    m_read_data = '0;
    unique case (state_q)
      ARB_IDLE: if (rr_any) begin
        grant_d = rr_id;
        clr_cnt = 1'b1;
        if (legal) begin
          state_d = ARB_BUSY;
          s_valid_d = 1'b1;
          s_read_d = m_read[rr_id];
          s_write_d = m_write[rr_id];
          s_addr_d = m_addr[int'(rr_id)*ADDR_W +: ADDR_W];
          s_wd_d = m_write_data[int'(rr_id)*DATA_W +: DATA_W];
        end else begin
          state_d = ARB_ERR;
        end
      end
      ARB_BUSY: if (s_ready || timeout) begin
        m_ready[grant_q] = 1'b1;
        m_err[grant_q] = !s_ready;
        m_read_data = s_ready ? s_read_data : '0;
        s_valid_d = 1'b0;
        ptr_d = nxt_ptr;
        state_d = ARB_IDLE;
      end
      ARB_ERR: begin
        m_ready[grant_q] = 1'b1;
        m_err[grant_q] = 1'b1;
        ptr_d = nxt_ptr;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // state and slave-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      s_valid_q <= 1'b0;
      s_read_q <= 1'b0;
      s_write_q <= 1'b0;
      s_addr_q <= '0;
      s_wd_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      s_valid_q <= s_valid_d;
      s_read_q <= s_read_d;
      s_write_q <= s_write_d;
      s_addr_q <= s_addr_d;
      s_wd_q <= s_wd_d;
    end
  end

  assign s_valid = s_valid_q;
  assign s_read = s_read_q;
  assign s_write = s_write_q;
  assign s_addr = s_addr_q;
  assign s_write_data = s_wd_q;
  assign grant_id = grant_q;
  assign busy = state_q != ARB_IDLE;
endmodule
